// File: rtl/cdc_pkg.sv
// Shared types and helpers for the source side of the pulse clock-crossing.
// Holds the transmitter FSM state encoding and the hold-counter sizing rule.
package cdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cdc_tx_state_t;

    // Width that can hold HOLD_CYCLES-1; never narrower than one bit.
    function automatic int hold_cnt_width(input int hold_cycles);
        return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
    endfunction

endpackage

// File: rtl/cdc_event_tx_if.sv
// Event handshake and status bundle between a producer and cdc_event_tx.
// The producer uses the master view and the transmitter uses the slave view.
interface cdc_event_tx_if #(
    parameter int PENDING_WIDTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     toggle_out;
    logic [PENDING_WIDTH-1:0] pending;
    logic                     busy;

    modport master (
        output in_valid,
        input  in_ready, toggle_out, pending, busy
    );

    modport slave (
        input  in_valid,
        output in_ready, toggle_out, pending, busy
    );
endinterface

// File: rtl/cdc_event_tx.sv
// Encodes accepted events as toggle_out transitions spaced at least HOLD_CYCLES
// clocks apart; events arriving faster are queued in a saturating pending count.
module cdc_event_tx
    import cdc_pkg::*;
#(
    parameter int HOLD_CYCLES   = 4,
    parameter int PENDING_WIDTH = 4
) (
    input  logic            clk,
    input  logic            areset,
    cdc_event_tx_if.slave   ev
);

    localparam int HW = hold_cnt_width(HOLD_CYCLES);
    localparam int PW = PENDING_WIDTH;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PMAX        = '1;
    localparam logic [PW-1:0] P_ONE       = PW'(1);

    generate
        if (HOLD_CYCLES < 2) begin : g_bad_hold
            $error("cdc_event_tx: HOLD_CYCLES must be at least 2");
        end
    endgenerate

    cdc_tx_state_t  state_q, state_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]  pending_q, pending_d;
    logic           toggle_q, toggle_d;

    logic           ready_w;
    logic           accept_w;

    // Ready depends only on registered state; reset gating is added at the port.
    assign ready_w  = (pending_q != PMAX);
    assign accept_w = ev.in_valid && ready_w;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            pending_q  <= '0;
            toggle_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pending_q  <= pending_d;
            toggle_q   <= toggle_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pending_d  = pending_q;
        toggle_d   = toggle_q;
        unique case (state_q)
            IDLE: begin
                if (accept_w) begin
                    toggle_d   = ~toggle_q;
                    hold_cnt_d = HOLD_RELOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                    if (accept_w) begin
                        pending_d = pending_q + P_ONE;
                    end
                end else if ((pending_q != '0) || accept_w) begin
                    // Dispatch edge: a same-edge accept replaces the dequeued event.
                    toggle_d   = ~toggle_q;
                    hold_cnt_d = HOLD_RELOAD;
                    if ((pending_q != '0) && !accept_w) begin
                        pending_d = pending_q - P_ONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ev.in_ready   = !areset && ready_w;
        ev.busy       = (state_q == HOLD) || (pending_q != '0);
        ev.toggle_out = toggle_q;
        ev.pending    = pending_q;
    end

endmodule
